// File: rtl/rv_elastic_buf.sv
// DEPTH-entry ready/valid elastic buffer with registered occupancy, strict FIFO order,
// synchronous flush and an occupancy count; in_ready never depends on out_ready.
module rv_elastic_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths behave exactly like power-of-two ones.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_reg != FULL_CNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr_reg];
    assign count     = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is never cleared; a write is simply suppressed while reset or flush discards it.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: tb/tb_rv_elastic_buf.sv
// Bench for rv_elastic_buf: three instances (DEPTH 4, 3, 5) checked every cycle against
// a queue-based reference model.
module tb_rv_elastic_buf;

    localparam int NI = 3;
    localparam int DEP [NI] = '{4, 3, 5};

    logic       clk = 1'b0;
    logic       rst_a       [NI];
    logic       flush_a     [NI];
    logic       in_valid_a  [NI];
    logic       in_ready_a  [NI];
    logic [7:0] in_data_a   [NI];
    logic       out_valid_a [NI];
    logic       out_ready_a [NI];
    logic [7:0] out_data_a  [NI];
    logic [3:0] count_a     [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int D  = DEP[gi];
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] cnt;
        rv_elastic_buf #(.DATA_W(8), .DEPTH(D)) u_dut (
            .clk       (clk),
            .rst       (rst_a[gi]),
            .flush     (flush_a[gi]),
            .in_valid  (in_valid_a[gi]),
            .in_ready  (in_ready_a[gi]),
            .in_data   (in_data_a[gi]),
            .out_valid (out_valid_a[gi]),
            .out_ready (out_ready_a[gi]),
            .out_data  (out_data_a[gi]),
            .count     (cnt)
        );
        assign count_a[gi] = 4'(cnt);
    end

    logic [7:0] q [NI][$];
    bit         armed  [NI];
    int         n_push [NI];
    int         n_pop  [NI];
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: compare outputs to the model, then apply the handshake rules.
    task automatic step();
        bit push_e [NI];
        bit pop_e  [NI];
        for (int k = 0; k < NI; k++) begin
            if (armed[k]) begin
                chk($sformatf("count%0d", k), 32'(count_a[k]), 32'(q[k].size()));
                chk($sformatf("in_ready%0d", k), 32'(in_ready_a[k]), 32'(q[k].size() != DEP[k]));
                chk($sformatf("out_valid%0d", k), 32'(out_valid_a[k]), 32'(q[k].size() != 0));
                if (q[k].size() != 0)
                    chk($sformatf("out_data%0d", k), 32'(out_data_a[k]), 32'(q[k][0]));
            end
            push_e[k] = in_valid_a[k] && (q[k].size() != DEP[k]);
            pop_e[k]  = out_ready_a[k] && (q[k].size() != 0);
        end
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (rst_a[k]) begin
                q[k].delete();
                armed[k] = 1'b1;
            end else if (flush_a[k]) begin
                q[k].delete();
            end else begin
                if (pop_e[k]) begin
                    void'(q[k].pop_front());
                    n_pop[k]++;
                end
                if (push_e[k]) begin
                    q[k].push_back(in_data_a[k]);
                    n_push[k]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < NI; k++) begin
            rst_a[k]       = 1'b0;
            flush_a[k]     = 1'b0;
            in_valid_a[k]  = 1'b0;
            in_data_a[k]   = 8'h00;
            out_ready_a[k] = 1'b0;
        end
    endtask

    initial begin
        logic hold;
        int   cyc;
        idle_inputs();
        for (int k = 0; k < NI; k++) begin
            rst_a[k]  = 1'b1;
            armed[k]  = 1'b0;
            n_push[k] = 0;
            n_pop[k]  = 0;
        end
        @(negedge clk);
        step();
        step();
        for (int k = 0; k < NI; k++) rst_a[k] = 1'b0;
        step();

        // Fill DEPTH=4 and hold a fifth beat while full.
        in_valid_a[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data_a[0] = 8'(i * 8'h11);
            step();
        end
        in_data_a[0] = 8'h55;
        step();
        chk("held_55_not_taken", 32'(n_push[0]), 32'd4);

        // Full with a ready consumer: bubble, then 0x55 enters.
        out_ready_a[0] = 1'b1;
        step();
        step();
        in_valid_a[0] = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("fill_pops", 32'(n_pop[0]), 32'd5);

        // Flush at count 3 together with a push and a pop.
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data_a[0] = 8'(8'hA1 + i);
            step();
        end
        flush_a[0]     = 1'b1;
        in_data_a[0]   = 8'hAA;
        out_ready_a[0] = 1'b1;
        step();
        flush_a[0]     = 1'b0;
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b0;
        step();
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 8'hBB;
        step();
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        step();
        step();

        // Reset at count 2 while a beat is offered.
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data_a[0] = 8'(8'hC1 + i);
            step();
        end
        rst_a[0]     = 1'b1;
        in_data_a[0] = 8'hC9;
        step();
        rst_a[0]     = 1'b0;
        in_valid_a[0] = 1'b0;
        step();
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 8'hD0;
        step();
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        step();
        step();
        out_ready_a[0] = 1'b0;

        // Streaming 0..9 through DEPTH=3 with the consumer always ready.
        out_ready_a[1] = 1'b1;
        in_valid_a[1]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data_a[1] = 8'(i);
            chk("stream_max_cnt", 32'(count_a[1] > 4'd1), 32'd0);
            step();
        end
        in_valid_a[1] = 1'b0;
        step();
        step();
        chk("stream_pops", 32'(n_pop[1]), 32'd10);

        // Random backpressure on DEPTH=5; producer holds a refused beat.
        hold = 1'b0;
        cyc  = 0;
        while (n_push[2] < 1000 && cyc < 20000) begin
            if (!hold) begin
                in_valid_a[2] = 1'($urandom_range(0, 1));
                in_data_a[2]  = 8'($urandom);
            end
            out_ready_a[2] = 1'($urandom_range(0, 1));
            hold = in_valid_a[2] && (q[2].size() == DEP[2]);
            step();
            cyc++;
        end
        in_valid_a[2]  = 1'b0;
        out_ready_a[2] = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("rand_pushes", 32'(n_push[2]), 32'd1000);
        chk("rand_pops", 32'(n_pop[2]), 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
